// File: rtl/exp_lut_pkg.sv
// Shared constants and types for the exp coefficient LUT and its arbiter.
// Coefficients are Q5.26 signed values; the LUT has 8 segments.
package exp_lut_pkg;

  localparam int unsigned Q            = 26;
  localparam int unsigned W            = 32;
  localparam int unsigned NUM_SEGMENTS = 8;
  localparam int unsigned SEG_W        = 3;
  localparam int unsigned NUM_PORTS    = 32;

  typedef logic [SEG_W-1:0]        seg_idx_t;
  typedef logic signed [W-1:0]     coeff_t;
  typedef seg_idx_t [NUM_PORTS-1:0] seg_vec_t;
  typedef coeff_t [NUM_PORTS-1:0]   coeff_vec_t;

  // Occupancy of the single-entry response register.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted req at or
// after ptr, wrapping modulo N.
// Ports: req (N), ptr (IDX_W) -> grant (one-hot or zero), grant_idx.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic        found;
  int unsigned idx;

  // Scan N positions starting at ptr; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!found && req[IDX_W'(idx)]) begin
        found                = 1'b1;
        grant[IDX_W'(idx)]   = 1'b1;
        grant_idx            = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/exp_lut_arbiter.sv
// Shares one exp coefficient LUT bank among NUM_REQ requesters. One request
// vector is granted per cycle in round-robin order; the combinational LUT
// result is captured into a single-entry response register tagged with the
// requester id.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     per-requester handshake (ready one-hot or zero)
//   req_seg                 per-requester segment index vectors
//   lut_seg_idx             segment indices to the LUT (zero when idle)
//   lut_k, lut_b            combinational LUT coefficients
//   rsp_valid/rsp_ready     response handshake
//   rsp_id, rsp_k, rsp_b    registered response
// Optional: define EXP_LUT_ARB_STATS_EN to add stat_grants / stat_stall
// saturating counters.
module exp_lut_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned NUM_PORTS = 32,
  parameter int unsigned W         = exp_lut_pkg::W,
  parameter int unsigned SEG_W     = exp_lut_pkg::SEG_W,
  parameter int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*NUM_PORTS*SEG_W-1:0] req_seg,
  output logic [NUM_PORTS*SEG_W-1:0]         lut_seg_idx,
  input  logic [NUM_PORTS*W-1:0]             lut_k,
  input  logic [NUM_PORTS*W-1:0]             lut_b,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [ID_W-1:0]                    rsp_id,
  output logic [NUM_PORTS*W-1:0]             rsp_k,
  output logic [NUM_PORTS*W-1:0]             rsp_b
`ifdef EXP_LUT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]              stat_grants,
  output logic [15:0]                        stat_stall
`endif
);

  import exp_lut_pkg::*;

  localparam int unsigned SEG_VEC_W = NUM_PORTS * SEG_W;

  slot_state_t          state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]   grant;
  logic                 slot_free;
  logic                 grant_any;

  // The register can take new data when empty or when it drains this cycle.
  assign slot_free = (state == EMPTY) || rsp_ready;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req       (req_valid & {NUM_REQ{slot_free}}),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Gated by rst_n so no requester sees a handshake while reset is held.
  assign req_ready = grant & {NUM_REQ{rst_n}};
  assign grant_any = |req_ready;

  // Route the granted requester's indices to the LUT; zero when idle.
  always_comb begin
    lut_seg_idx = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (req_ready[r]) begin
        lut_seg_idx = req_seg[r*SEG_VEC_W +: SEG_VEC_W];
      end
    end
  end

  assign rsp_valid = (state == FULL);

  // Response register, occupancy FSM and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      rr_ptr <= '0;
      rsp_id <= '0;
      rsp_k  <= '0;
      rsp_b  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (grant_any) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (rsp_ready && !grant_any) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      if (grant_any) begin
        rsp_k  <= lut_k;
        rsp_b  <= lut_b;
        rsp_id <= grant_idx;
        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
    end
  end

`ifdef EXP_LUT_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt;

  assign stat_grants = grant_cnt;

  // Saturating per-requester grant counters and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt  <= '0;
      stat_stall <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (req_ready[r] && (grant_cnt[r] != 16'hFFFF)) begin
          grant_cnt[r] <= grant_cnt[r] + 16'd1;
        end
      end
      if ((state == FULL) && !rsp_ready && (|req_valid) && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exp_lut_arbiter.sv
// Directed bench for exp_lut_arbiter with a behavioural 8-entry LUT.
module tb_exp_lut_arbiter;

  localparam int unsigned NR  = 2;
  localparam int unsigned NP  = 32;
  localparam int unsigned CW  = 32;
  localparam int unsigned SW  = 3;
  localparam int unsigned VW  = NP * CW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR*NP*SW-1:0]  req_seg;
  logic [NP*SW-1:0]     lut_seg_idx;
  logic [VW-1:0]        lut_k;
  logic [VW-1:0]        lut_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [VW-1:0]        rsp_k;
  logic [VW-1:0]        rsp_b;
`ifdef EXP_LUT_ARB_STATS_EN
  logic [NR*16-1:0]     stat_grants;
  logic [15:0]          stat_stall;
`endif

  int nchk  = 0;
  int nfail = 0;

  exp_lut_arbiter #(
    .NUM_REQ(NR), .NUM_PORTS(NP), .W(CW), .SEG_W(SW), .ID_W(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_seg     (req_seg),
    .lut_seg_idx (lut_seg_idx),
    .lut_k       (lut_k),
    .lut_b       (lut_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_k       (rsp_k),
    .rsp_b       (rsp_b)
`ifdef EXP_LUT_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] kf(input logic [2:0] s);
    case (s)
      3'd0: kf = 32'h02E57078;
      3'd1: kf = 32'h031A2B3C;
      3'd2: kf = 32'h0368ACE0;
      3'd3: kf = 32'h03C18722;
      3'd4: kf = 32'h04200000;
      3'd5: kf = 32'h04862A10;
      3'd6: kf = 32'h04F31D5A;
      default: kf = 32'h054FCE46;
    endcase
  endfunction

  function automatic logic [31:0] bf(input logic [2:0] s);
    case (s)
      3'd0: bf = 32'h04000000;
      3'd1: bf = 32'h03E1C4A0;
      3'd2: bf = 32'h03D5E6F0;
      3'd3: bf = 32'h03C76408;
      3'd4: bf = 32'h03A00000;
      3'd5: bf = 32'h0361B2C4;
      3'd6: bf = 32'h02F81D00;
      default: bf = 32'h02B031B9;
    endcase
  endfunction

  // Behavioural LUT bank: combinational per lane.
  always_comb begin
    lut_k = '0;
    lut_b = '0;
    for (int l = 0; l < NP; l++) begin
      lut_k[l*CW +: CW] = kf(lut_seg_idx[l*SW +: SW]);
      lut_b[l*CW +: CW] = bf(lut_seg_idx[l*SW +: SW]);
    end
  end

  function automatic logic [NR*NP*SW-1:0] uni(input logic [2:0] s0, input logic [2:0] s1);
    logic [NR*NP*SW-1:0] v;
    v = '0;
    for (int l = 0; l < NP; l++) begin
      v[l*SW +: SW]        = s0;
      v[(NP+l)*SW +: SW]   = s1;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (low 64 bits)", nm, act[63:0], exp[63:0]);
    end
  endtask

  typedef struct {
    logic [1:0] valid;
    logic       ready;
    logic [2:0] s0;
    logic [2:0] s1;
    logic [1:0] e_ready;
    logic       e_valid;
    logic       chk_data;
    logic       e_id;
    logic [2:0] e_seg;
  } vec_t;

  // Drive one vector at a negedge, check ready before the edge and the
  // response after it; returns at the following negedge.
  task automatic apply(input vec_t v, input string tag);
    req_valid = v.valid;
    rsp_ready = v.ready;
    req_seg   = uni(v.s0, v.s1);
    #1;
    chk({tag, " req_ready"}, VW'(req_ready), VW'(v.e_ready));
    @(posedge clk);
    #1;
    chk({tag, " rsp_valid"}, VW'(rsp_valid), VW'(v.e_valid));
    if (v.chk_data) begin
      chk({tag, " rsp_id"}, VW'(rsp_id), VW'(v.e_id));
      chk({tag, " rsp_k"}, rsp_k, {NP{kf(v.e_seg)}});
      chk({tag, " rsp_b"}, rsp_b, {NP{bf(v.e_seg)}});
    end
    @(negedge clk);
  endtask

  vec_t tbl[14];
  vec_t v;
  logic [VW-1:0] ek, eb;

  initial begin
    //        valid  rdy  s0    s1    e_rdy  e_v  data  id    seg
    tbl[0]  = '{2'b11, 1'b1, 3'd3, 3'd7, 2'b01, 1'b1, 1'b1, 1'b0, 3'd3};
    tbl[1]  = '{2'b11, 1'b1, 3'd3, 3'd7, 2'b10, 1'b1, 1'b1, 1'b1, 3'd7};
    tbl[2]  = '{2'b11, 1'b1, 3'd3, 3'd7, 2'b01, 1'b1, 1'b1, 1'b0, 3'd3};
    tbl[3]  = '{2'b11, 1'b1, 3'd3, 3'd7, 2'b10, 1'b1, 1'b1, 1'b1, 3'd7};
    tbl[4]  = '{2'b01, 1'b1, 3'd0, 3'd7, 2'b01, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[5]  = '{2'b11, 1'b0, 3'd3, 3'd7, 2'b00, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[6]  = '{2'b11, 1'b0, 3'd3, 3'd7, 2'b00, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[7]  = '{2'b11, 1'b0, 3'd3, 3'd7, 2'b00, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[8]  = '{2'b11, 1'b1, 3'd3, 3'd7, 2'b10, 1'b1, 1'b1, 1'b1, 3'd7};
    tbl[9]  = '{2'b00, 1'b1, 3'd3, 3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[10] = '{2'b10, 1'b0, 3'd3, 3'd7, 2'b10, 1'b1, 1'b1, 1'b1, 3'd7};
    tbl[11] = '{2'b01, 1'b0, 3'd3, 3'd7, 2'b00, 1'b1, 1'b1, 1'b1, 3'd7};
    tbl[12] = '{2'b10, 1'b1, 3'd3, 3'd7, 2'b10, 1'b1, 1'b1, 1'b1, 3'd7};
    tbl[13] = '{2'b01, 1'b1, 3'd3, 3'd7, 2'b01, 1'b1, 1'b1, 1'b0, 3'd3};

    // Reset with both requesters asking.
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    req_seg   = uni(3'd3, 3'd7);
    repeat (2) @(negedge clk);
    chk("reset req_ready", VW'(req_ready), VW'(2'b00));
    chk("reset rsp_valid", VW'(rsp_valid), VW'(1'b0));
    chk("reset rsp_id",    VW'(rsp_id),    VW'(1'b0));
    chk("reset rsp_k",     rsp_k,          '0);
    chk("reset rsp_b",     rsp_b,          '0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Mixed lanes on req1 (rr_ptr is 1 here), then pointer wraps to req0.
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    req_seg   = uni(3'd3, 3'd0);
    for (int l = 0; l < NP; l++) begin
      req_seg[(NP+l)*SW +: SW] = 3'(l % 8);
      ek[l*CW +: CW] = kf(3'(l % 8));
      eb[l*CW +: CW] = bf(3'(l % 8));
    end
    #1;
    chk("mixed req_ready", VW'(req_ready), VW'(2'b10));
    @(posedge clk);
    #1;
    chk("mixed rsp_id", VW'(rsp_id), VW'(1'b1));
    chk("mixed rsp_k", rsp_k, ek);
    chk("mixed rsp_b", rsp_b, eb);
    @(negedge clk);
    v = '{2'b11, 1'b1, 3'd3, 3'd7, 2'b01, 1'b1, 1'b1, 1'b0, 3'd3};
    apply(v, "after_mixed");

    // Mid-operation reset while FULL and stalled.
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst rsp_valid", VW'(rsp_valid), VW'(1'b0));
    chk("midrst req_ready", VW'(req_ready), VW'(2'b00));
    chk("midrst rsp_k",     rsp_k,          '0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("postrst rsp_valid", VW'(rsp_valid), VW'(1'b0));
    @(negedge clk);
    v = '{2'b11, 1'b1, 3'd7, 3'd3, 2'b01, 1'b1, 1'b1, 1'b0, 3'd7};
    apply(v, "postrst_grant");

`ifdef EXP_LUT_ARB_STATS_EN
    // Saturate requester 0's grant counter.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk("stat_grants0 sat", VW'(stat_grants[15:0]), VW'(16'hFFFF));
    chk("stat_grants1",     VW'(stat_grants[31:16]), VW'(16'h0000));
    chk("stat_stall",       VW'(stat_stall),         VW'(16'h0000));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
